// File: rtl/dense_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dense_layer_ctrl
// Description : Sequences one fixed-point MAC neuron through a dense layer.
//               Holds the layer input vector locally, streams weights and
//               biases from a 1-cycle synchronous weight memory, and emits a
//               ReLU activation per output neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_layer_ctrl #(
  parameter  int N_IN  = 16,
  parameter  int N_OUT = 8,
  parameter  int AW    = 8,
  localparam int IW    = $clog2(N_IN),
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_wr_en,
  input  logic [IW-1:0] in_wr_addr,
  input  logic [31:0]   in_wr_data,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic          n_zero,
  output logic          n_isbias,
  output logic [31:0]   n_input,
  output logic [31:0]   n_weight,
  output logic [31:0]   n_last,
  input  logic [31:0]   n_out,
  output logic          busy,
  output logic          out_valid,
  output logic [OW-1:0] out_idx,
  output logic [31:0]   out_data,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_BIAS  = 3'd3,
    S_ACT   = 3'd4
  } state_t;

  // Distance between consecutive neuron records: N_IN weights plus one bias
  localparam logic [AW-1:0] C_STRIDE = AW'(N_IN + 1);
  localparam logic [IW-1:0] C_K_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] C_J_LAST = OW'(N_OUT - 1);

  state_t        r_state;
  logic [IW-1:0] r_k;
  logic [OW-1:0] r_j;
  logic [AW-1:0] r_base;
  logic [31:0]   r_buf [N_IN];
  logic          r_out_valid;
  logic [OW-1:0] r_out_idx;
  logic [31:0]   r_out_data;
  logic          r_done;

  logic          w_last_neuron;

  assign w_last_neuron = (r_j == C_J_LAST);
  assign n_last        = n_out;
  assign busy          = (r_state != S_IDLE);
  assign out_valid     = r_out_valid;
  assign out_idx       = r_out_idx;
  assign out_data      = r_out_data;
  assign done          = r_done;

  // Neuron and weight-memory controls decoded from the registered state
  always_comb begin
    w_rd_en  = 1'b0;
    w_addr   = '0;
    n_zero   = 1'b0;
    n_isbias = 1'b0;
    n_input  = '0;
    n_weight = '0;
    unique case (r_state)
      S_IDLE: begin
        n_zero = 1'b1;
      end
      S_CLEAR: begin
        n_zero  = 1'b1;
        w_rd_en = 1'b1;
        w_addr  = '0;
      end
      S_MAC: begin
        n_input  = r_buf[r_k];
        n_weight = w_data;
        w_rd_en  = 1'b1;
        // Prefetch the next word; on the last MAC this is the bias
        w_addr   = r_base + AW'(r_k) + AW'(1);
      end
      S_BIAS: begin
        n_isbias = 1'b1;
        n_weight = w_data;
      end
      S_ACT: begin
        // Clearing here lets the next neuron start MAC with no CLEAR cycle
        n_zero = 1'b1;
        if (!w_last_neuron) begin
          w_rd_en = 1'b1;
          w_addr  = r_base + C_STRIDE;
        end
      end
      default: begin
        n_zero = 1'b1;
      end
    endcase
  end

  // Layer sequencer, input buffer writes and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_j         <= '0;
      r_base      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_wr_en && (int'(in_wr_addr) < N_IN)) begin
            r_buf[in_wr_addr] <= in_wr_data;
          end
          if (start) begin
            r_state <= S_CLEAR;
            r_j     <= '0;
            r_k     <= '0;
            r_base  <= '0;
          end
        end
        S_CLEAR: begin
          r_state <= S_MAC;
          r_k     <= '0;
        end
        S_MAC: begin
          if (r_k == C_K_LAST) begin
            r_state <= S_BIAS;
            r_k     <= '0;
          end else begin
            r_k <= r_k + IW'(1);
          end
        end
        S_BIAS: begin
          r_state <= S_ACT;
        end
        S_ACT: begin
          // ReLU only inspects the sign bit; the neuron itself wraps
          r_out_valid <= 1'b1;
          r_out_idx   <= r_j;
          r_out_data  <= n_out[31] ? 32'd0 : n_out;
          if (w_last_neuron) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_j     <= r_j + OW'(1);
            r_base  <= r_base + C_STRIDE;
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_layer_ctrl
// Description : Directed self-checking bench for dense_layer_ctrl with a
//               behavioural MAC neuron and a 1-cycle weight RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_layer_ctrl;

  localparam int NI   = 16;
  localparam int NO   = 8;
  localparam int PER  = NI + 2;
  localparam int LAST = NO * PER + 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_wr_en;
  logic [3:0]  in_wr_addr;
  logic [31:0] in_wr_data;
  logic        w_rd_en;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        n_zero;
  logic        n_isbias;
  logic [31:0] n_input;
  logic [31:0] n_weight;
  logic [31:0] n_last;
  logic [31:0] n_out;
  logic        busy;
  logic        out_valid;
  logic [2:0]  out_idx;
  logic [31:0] out_data;
  logic        done;

  logic [31:0] wmem [256];
  logic [31:0] exp_res [NO];
  logic [63:0] prod;
  int          errors = 0;
  int          checks = 0;

  dense_layer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_wr_en   (in_wr_en),
    .in_wr_addr (in_wr_addr),
    .in_wr_data (in_wr_data),
    .w_rd_en    (w_rd_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .n_zero     (n_zero),
    .n_isbias   (n_isbias),
    .n_input    (n_input),
    .n_weight   (n_weight),
    .n_last     (n_last),
    .n_out      (n_out),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous weight RAM, one cycle of read latency
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
  end

  // Behavioural neuron: clear, Q1.31 truncating MAC, bias add, wrapping
  assign prod = $signed({{32{n_input[31]}}, n_input}) * $signed({{32{n_weight[31]}}, n_weight});
  always @(posedge clk or posedge rst) begin
    if (rst)           n_out <= 32'd0;
    else if (n_zero)   n_out <= 32'd0;
    else if (n_isbias) n_out <= n_out + n_weight;
    else               n_out <= n_out + prod[62:31];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_weights(input logic [31:0] wt, input logic [31:0] n3wt, input logic [31:0] bias);
    for (int j = 0; j < NO; j++) begin
      for (int k = 0; k < NI; k++) wmem[j*(NI+1)+k] = (j == 3) ? n3wt : wt;
      wmem[j*(NI+1)+NI] = bias;
    end
  endtask

  // Caller raises start before the edge E0; cycle c is the period after E(c-1)
  task automatic run_pass(input bit hold, input bit inject);
    int  addr_exp;
    int  idx;
    bit  exp_valid;
    bit  exp_rd;
    addr_exp = 0;
    @(posedge clk);
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (c == 1) in_wr_en = 1'b0;
      if (inject && c == 50) begin
        start      = 1'b1;
        in_wr_en   = 1'b1;
        in_wr_addr = 4'd0;
        in_wr_data = 32'h7FFF_FFFF;
      end
      if (inject && c == 51) begin
        start    = 1'b0;
        in_wr_en = 1'b0;
      end
      exp_valid = (c >= PER + 2) && ((c - 2) % PER == 0);
      exp_rd    = (c <= LAST - 3) && !(c >= PER && (c % PER) == 0);
      chk("busy", busy, (c != LAST));
      chk("done", done, (c == LAST));
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        idx = (c - 2) / PER - 1;
        chk("out_idx", out_idx, idx);
        chk($sformatf("out_data[%0d]", idx), out_data, exp_res[idx]);
      end
      chk("w_rd_en", w_rd_en, exp_rd);
      if (exp_rd) begin
        chk("w_addr", w_addr, addr_exp);
        addr_exp++;
      end
      if (c == PER + 1) chk("n_last", n_last, n_out);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    in_wr_en   = 1'b0;
    in_wr_addr = 4'd0;
    in_wr_data = 32'd0;
    for (int i = 0; i < 256; i++) wmem[i] = 32'd0;
    set_weights(32'h0800_0000, 32'h0800_0000, 32'h1000_0000);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_idx", out_idx, 0);
    chk("rst out_data", out_data, 0);
    chk("rst w_rd_en", w_rd_en, 0);
    chk("rst w_addr", w_addr, 0);
    chk("rst n_zero", n_zero, 1);
    chk("rst n_isbias", n_isbias, 0);
    chk("rst n_input", n_input, 0);
    chk("rst n_weight", n_weight, 0);
    rst = 1'b0;

    // Load buffer; the last write coincides with start and must be used
    for (int i = 0; i < NI - 1; i++) begin
      in_wr_en   = 1'b1;
      in_wr_addr = 4'(i);
      in_wr_data = 32'h4000_0000;
      @(negedge clk);
    end
    in_wr_addr = 4'd15;
    start      = 1'b1;
    for (int i = 0; i < NO; i++) exp_res[i] = 32'h5000_0000;

    // Positive sums, address sequence, inputs ignored while busy
    run_pass(1'b0, 1'b1);

    // ReLU clamp on neuron 3; also proves the busy write was dropped
    set_weights(32'h0800_0000, 32'hF800_0000, 32'h1000_0000);
    exp_res[3] = 32'd0;
    start = 1'b1;
    run_pass(1'b0, 1'b0);
    set_weights(32'h0800_0000, 32'h0800_0000, 32'h1000_0000);

    // Reset mid-pass
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid busy", busy, 0);
    chk("mid out_valid", out_valid, 0);
    chk("mid done", done, 0);
    chk("mid out_data", out_data, 0);
    chk("mid out_idx", out_idx, 0);
    chk("mid w_rd_en", w_rd_en, 0);
    chk("mid w_addr", w_addr, 0);
    chk("mid n_zero", n_zero, 1);
    chk("mid n_input", n_input, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post-rst out_valid", out_valid, 0);
      chk("post-rst done", done, 0);
      chk("post-rst busy", busy, 0);
    end

    // Cleared buffer leaves only the bias
    for (int i = 0; i < NO; i++) exp_res[i] = 32'h1000_0000;
    start = 1'b1;
    run_pass(1'b0, 1'b0);

    // Back-to-back passes with start held high
    start = 1'b1;
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("idle busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dense_layer_ctrl.md
# dense_layer_ctrl

Sequencer that drives one fixed-point MAC neuron through a full dense layer. It holds the layer input vector in a local buffer and fetches weights and biases from an external synchronous weight memory. For each output neuron it issues the neuron's clear, multiply-accumulate and bias-add steps, then applies ReLU and emits the activation. It sits directly upstream of the `neural` MAC cell and also consumes that cell's `output_data`.

## Interface
- `N_IN`, 16: inputs per neuron, at least 2.
- `N_OUT`, 8: neurons in the layer, at least 1.
- `AW`, 8: weight address width; `2^AW` must be at least `N_OUT*(N_IN+1)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a layer pass; sampled only in IDLE.
- `in_wr_en` in 1: write the input buffer; ignored while `busy`.
- `in_wr_addr` in `clog2(N_IN)`: input buffer index.
- `in_wr_data` in 32: Q1.31 input sample.
- `w_rd_en` out 1: weight memory read strobe.
- `w_addr` out `AW`: weight memory address.
- `w_data` in 32: weight memory data; valid one cycle after `w_rd_en`.
- `n_zero` out 1: drives `neural.zero`.
- `n_isbias` out 1: drives `neural.isbias`.
- `n_input` out 32: drives `neural.input_data`.
- `n_weight` out 32: drives `neural.weight_data`.
- `n_last` out 32: drives `neural.last_data`; equals `n_out`.
- `n_out` in 32: from `neural.output_data`.
- `busy` out 1: high when the state is not IDLE.
- `out_valid` out 1: one-cycle pulse per neuron result.
- `out_idx` out `clog2(N_OUT)`: index of the neuron result.
- `out_data` out 32: ReLU(neuron sum), Q1.31.
- `done` out 1: one-cycle pulse when the layer pass completes.

## Operation
- Weight memory layout for neuron j, with base(j) = j*(N_IN+1):
  - addresses base(j)+0 .. base(j)+N_IN-1 hold the weights, in input order;
  - address base(j)+N_IN holds the bias.
- States are IDLE, CLEAR, MAC (counter k = 0..N_IN-1), BIAS and ACT. Neuron counter j runs 0..N_OUT-1.
- IDLE:
  - `n_zero`=1; `w_rd_en`=0.
  - `start`=1 moves to CLEAR with j=0.
  - Input buffer writes are accepted only in IDLE.
- CLEAR:
  - `n_zero`=1; issues `w_addr`=base(0), `w_rd_en`=1.
  - Next state is MAC with k=0.
- MAC k:
  - `n_input`=buf[k], `n_weight`=`w_data`, `n_zero`=0, `n_isbias`=0.
  - Issues `w_addr`=base(j)+k+1, `w_rd_en`=1.
  - k=N_IN-1 moves to BIAS.
- BIAS:
  - `n_isbias`=1, `n_weight`=`w_data`, `w_rd_en`=0.
  - Next state is ACT.
- ACT:
  - `n_out` holds the complete sum.
  - Registers `out_data` = (`n_out[31]` ? 0 : `n_out`), `out_idx`=j and `out_valid`=1 for the following cycle.
  - `n_zero`=1, which clears the neuron for the next neuron.
  - If j<N_OUT-1: issues `w_addr`=base(j+1), `w_rd_en`=1, increments j, moves to MAC with k=0.
  - Otherwise: registers `done`=1 and moves to IDLE.
- In non-MAC/BIAS states `n_input`=0 and `n_weight`=0. `n_last` is always `n_out`, a pure wire.
- Arithmetic:
  - The neuron wraps on overflow and truncates each product to Q1.31.
  - This block adds no saturation; ReLU only tests bit 31.
- Simultaneous events:
  - `start` together with `in_wr_en` in IDLE: the write completes and the pass starts. The pass uses the old buffer value at that index only if k=0 reads it in the same cycle, which is impossible because CLEAR intervenes. The new value is therefore used.
  - `start` while `busy` is ignored.
  - `start` in the same cycle as `done` is accepted, because the state is already IDLE.
- Reset mid-operation: the block returns to IDLE immediately. A partial result is never emitted, and `done` is not pulsed.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `out_valid`=0, `out_idx`=0, `out_data`=0.
  - `w_rd_en`=0, `w_addr`=0.
  - `n_zero`=1, `n_isbias`=0, `n_input`=0, `n_weight`=0.
  - Input buffer is cleared to 0; j and k are 0.
- Control outputs are combinational from registered state and counters. `out_*` and `done` are registered.
- With `start` sampled at edge E0 (cycle 0):
  - cycle 1 is CLEAR;
  - each neuron then takes N_IN+2 cycles (N_IN MAC, 1 BIAS, 1 ACT).
- `out_valid` for neuron j is high in cycle (j+1)*(N_IN+2)+2. `done` is high in cycle N_OUT*(N_IN+2)+2, the same cycle as the last `out_valid`.
- `busy` falls in the cycle `done` rises.
- Weight read latency is exactly 1 cycle; no back-pressure on the `out_*` outputs.

## Test plan
All scenarios use defaults with a `neural` instance and a 1-cycle weight RAM model.
- Positive sums:
  - Stimulus: buffer all 0x40000000; every weight 0x08000000; biases 0x10000000.
  - Response: 8 pulses of `out_data`=0x50000000, `out_idx` 0..7, at cycles 20, 38, ..., 146; `done` at 146.
- ReLU clamp:
  - Stimulus: as above, but neuron 3 weights 0xF8000000.
  - Response: neuron 3 gives `out_data`=0 (sum -0.375); the other neurons give 0x50000000.
- Address sequence:
  - Stimulus: monitor `w_addr` with `w_rd_en`=1.
  - Response: the sequence is exactly 0..135 in order; the BIAS cycles show `w_rd_en`=0.
- Ignored inputs while busy:
  - Stimulus: `start` and `in_wr_en` (writing 0x7FFFFFFF) asserted at cycle 50.
  - Response: results unchanged; no restart; the buffer keeps its old value.
- Reset mid-pass:
  - Stimulus: `rst` at cycle 30.
  - Response: all outputs return to reset values, including an empty (zero) buffer. A new `start` then gives 8 results of 0x10000000.
- Back-to-back passes:
  - Stimulus: `start` held high.
  - Response: the second pass starts the cycle `done` pulses, and its first `out_valid` comes 146+20 cycles after E0.
